// File: rtl/pin_stream_bridge.sv
// Chip-side GPIO pin streaming endpoint: pin input bytes -> internal stream via a
// staged FIFO, internal 16-bit stream -> pins via a two-entry skid, plus debug counters.
module pin_stream_bridge #(
    parameter int IN_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic [37:0]      io_in,
    output logic [37:0]      io_out,
    output logic [37:0]      io_oeb,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [CNT_W-1:0] in_beats,
    output logic [CNT_W-1:0] out_beats,
    output logic             overflow
);

    localparam int PTR_W = $clog2(IN_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FIFO_FULL = OCC_W'(IN_DEPTH);
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(IN_DEPTH - 2);
    // Driven pins: 27 (in_ready) and 25..8 (out_valid, out_last, out_data).
    localparam logic [37:0] PIN_OEB = {10'h3ff, 1'b0, 1'b1, 18'h0, 8'hff};

    if ((IN_DEPTH < 4) || ((IN_DEPTH & (IN_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("IN_DEPTH must be a power of two and at least 4");
    end

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } in_beat_t;

    // ---------------------------------------------------------------- pin decode
    logic       in_valid_pin;
    logic       in_last_pin;
    logic       out_ready_pin;
    logic [7:0] in_data_pin;
    logic       unused_pins;

    assign in_valid_pin  = io_in[28];
    assign in_last_pin   = io_in[29];
    assign out_ready_pin = io_in[26];
    assign unused_pins   = ^{io_in[27], io_in[25:0]};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        in_data_pin = '0;
        for (int i = 0; i < 8; i++) begin
            in_data_pin[i] = io_in[37 - i];
        end
    end

    // ---------------------------------------------------------------- input path
    logic                 in_ready_q;
    logic                 stage_valid_q;
    in_beat_t             stage_q;
    in_beat_t             mem [IN_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [OCC_W-1:0]     count_q;
    logic [OCC_W-1:0]     count_next;
    logic [OCC_W-1:0]     occ_next;
    logic                 in_accept;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 drop;
    in_beat_t             head;

    assign in_accept = in_valid_pin & in_ready_q;
    assign fifo_full = (count_q == FIFO_FULL);
    assign m_valid   = (count_q != '0);
    assign pop       = m_valid & m_ready;
    assign push      = stage_valid_q & (~fifo_full | pop);
    assign drop      = stage_valid_q & fifo_full & ~pop;
    assign head      = mem[rd_ptr_q];
    assign m_data    = head.data;
    assign m_last    = head.last;

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + 1'b1;
        end else if (pop && !push) begin
            count_next = count_q - 1'b1;
        end
    end

    // Ready is a flop, so it must leave room for the one beat that can still arrive.
    assign occ_next = count_next + {{PTR_W{1'b0}}, in_accept};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            in_ready_q    <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow      <= 1'b0;
            in_beats      <= '0;
        end else begin
            in_ready_q    <= enable && (occ_next <= OCC_LIMIT);
            stage_valid_q <= in_accept;
            if (in_accept) begin
                stage_q  <= '{last: in_last_pin, data: in_data_pin};
                in_beats <= in_beats + CNT_W'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_next;
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; count_q qualifies every entry, so stale contents are never seen.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= stage_q;
        end
    end

    // ---------------------------------------------------------------- output path
    logic        out_valid_q;
    logic        out_last_q;
    logic [15:0] out_data_q;
    logic        skid_valid_q;
    logic        skid_last_q;
    logic [15:0] skid_data_q;
    logic        s_ready_q;
    logic        skid_valid_next;
    logic        out_complete;
    logic        s_accept;
    logic        main_load;
    logic        skid_load;

    assign out_complete = out_valid_q & out_ready_pin;
    assign s_accept     = s_valid & s_ready_q;
    assign main_load    = out_complete | ~out_valid_q;
    assign skid_load    = s_accept & out_valid_q & ~out_complete;
    assign s_ready      = s_ready_q;

    // s_ready_q is only high while the skid is empty, so skid_load never overwrites a held beat.
    always_comb begin
        skid_valid_next = skid_valid_q;
        if (skid_load) begin
            skid_valid_next = 1'b1;
        end else if (skid_valid_q && main_load) begin
            skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
            out_beats    <= '0;
        end else begin
            if (main_load) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= skid_data_q;
                    out_last_q  <= skid_last_q;
                end else if (s_accept) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= s_data;
                    out_last_q  <= s_last;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            if (skid_load) begin
                skid_data_q <= s_data;
                skid_last_q <= s_last;
            end
            skid_valid_q <= skid_valid_next;
            s_ready_q    <= enable && !skid_valid_next;
            if (out_complete) out_beats <= out_beats + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------- pin drive
    always_comb begin
        io_out       = '0;
        io_out[27]   = in_ready_q;
        io_out[25]   = out_valid_q;
        io_out[24]   = out_last_q;
        io_out[23:8] = out_data_q;
    end

    assign io_oeb = PIN_OEB;

endmodule
